// File: rtl/div_tc_32_32.sv
// rtl/div_tc_32_32.sv - sequential radix-2 restoring divider, start/busy/done handshake; DIV_SIGNED_EN selects two's-complement mode
module div_tc_32_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             carry;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             unused_bits;

  // Trial subtraction: shifted partial remainder plus inverted divisor plus one
  assign shifted          = {r, q[WIDTH-1]};
  assign {carry, diff}    = {1'b0, shifted} + {1'b0, ~{1'b0, d}} + {{(WIDTH + 1){1'b0}}, 1'b1};
  // When the subtraction is kept the result is below the divisor, so the top bits are always zero
  assign unused_bits      = ^{diff[WIDTH], shifted[WIDTH]};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_res = neg_q ? (~q + 1'b1) : q;
  assign r_res = neg_r ? (~r + 1'b1) : r;

  // Sign correction flags; cleared for divide-by-zero so the raw dividend passes through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
      neg_r <= dividend[WIDTH-1] && (divisor != '0);
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_res = q;
  assign r_res = r;
`endif

  // Control FSM and datapath: accept, iterate WIDTH times, publish results for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            d    <= b_mag;
            cnt  <= CW'(WIDTH);
            dbz  <= (divisor == '0);
            if (divisor == '0) begin
              // Divide by zero skips the iterations: all-ones quotient, dividend as remainder
              r     <= dividend;
              q     <= '1;
              state <= FIX;
            end else begin
              r     <= '0;
              q     <= a_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          r   <= carry ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], carry};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient    <= q_res;
          remainder   <= r_res;
          div_by_zero <= dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_tc_32_32.sv
// tb/tb_div_tc_32_32.sv - scoreboard bench for div_tc_32_32
module tb_div_tc_32_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   prev_done = 1'b0;

  div_tc_32_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        chk("done_cycle", cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  // Called at a falling edge; start is sampled at the next rising edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.z = ez;
    e.cyc = cyc + ((b == 32'd0) ? 2 : 34);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 (t=%0t)", $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done();

    @(negedge clk);
    issue(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    wait_done();
    issue(32'h12345678, 32'h12345679, 32'd0, 32'h12345678, 1'b0);
    wait_done();

    @(negedge clk);
    issue(32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1);
    wait_done();
    issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    wait_done();

    // start held high with changing operands: only the first request counts
    @(negedge clk);
    begin
      exp_t e;
      dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      e.q = 32'd100; e.r = 32'd0; e.z = 1'b0; e.cyc = cyc + 34;
      sb.push_back(e);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dividend = 32'd77 + 32'(i) * 32'd13;
      divisor  = (i % 3 == 0) ? 32'd0 : 32'(i + 2);
    end
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Reset in the middle of an operation
    issue(32'd12345, 32'd11, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("postrst_busy", {31'd0, busy}, 32'd0);

`ifdef DIV_SIGNED_EN
    issue(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    wait_done();
    @(negedge clk);
    issue(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    wait_done();
    @(negedge clk);
    issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    wait_done();
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
